// File: rtl/el2_ifu_iccm_red_cam_if.sv
`default_nettype none
// ============================================================================
// el2_ifu_iccm_red_cam_if : port bundle for the ICCM redundant-row CAM
// Revision: 1.0
// ============================================================================
interface el2_ifu_iccm_red_cam_if #(
  parameter int NUM_RED = 4,
  parameter int AW      = 14,
  parameter int DW      = 39
);
  localparam int CW = $clog2(NUM_RED + 1);

  logic          rd_en;
  logic [AW-1:0] rd_addr0;
  logic [AW-1:0] rd_addr1;
  logic          wr_en0;
  logic          wr_en1;
  logic [AW-1:0] wr_addr0;
  logic [AW-1:0] wr_addr1;
  logic [DW-1:0] wr_data0;
  logic [DW-1:0] wr_data1;
  logic          correct_en;
  logic [AW-1:0] correct_addr;
  logic [DW-1:0] correct_data;
  logic          touch_en;
  logic          flush;
  logic          rd_hit0;
  logic          rd_hit1;
  logic [DW-1:0] rd_data0;
  logic [DW-1:0] rd_data1;
  logic          full;
  logic          evict;
  logic [CW-1:0] valid_cnt;

  modport master (
    output rd_en, rd_addr0, rd_addr1, wr_en0, wr_en1, wr_addr0, wr_addr1,
           wr_data0, wr_data1, correct_en, correct_addr, correct_data,
           touch_en, flush,
    input  rd_hit0, rd_hit1, rd_data0, rd_data1, full, evict, valid_cnt
  );

  modport slave (
    input  rd_en, rd_addr0, rd_addr1, wr_en0, wr_en1, wr_addr0, wr_addr1,
           wr_data0, wr_data1, correct_en, correct_addr, correct_data,
           touch_en, flush,
    output rd_hit0, rd_hit1, rd_data0, rd_data1, full, evict, valid_cnt
  );
endinterface
`default_nettype wire

// File: rtl/el2_ifu_iccm_red_cam.sv
`default_nettype none
// ============================================================================
// el2_ifu_iccm_red_cam : LRU-managed CAM of redundant ICCM rows
// Revision: 1.0
// ============================================================================
module el2_ifu_iccm_red_cam #(
  parameter int NUM_RED = 4,
  parameter int AW      = 14,
  parameter int DW      = 39
) (
  input  logic                    clk,
  input  logic                    rst_l,
  el2_ifu_iccm_red_cam_if.slave   bus
);
  localparam int RW = $clog2(NUM_RED);
  localparam int CW = $clog2(NUM_RED + 1);

  logic [NUM_RED-1:0] valid_q, valid_d;
  logic [AW-1:0]      addr_q [NUM_RED];
  logic [AW-1:0]      addr_d [NUM_RED];
  logic [DW-1:0]      data_q [NUM_RED];
  logic [DW-1:0]      data_d [NUM_RED];
  logic [RW-1:0]      rank_q [NUM_RED];
  logic [RW-1:0]      rank_d [NUM_RED];
  logic               rd_hit0_q, rd_hit0_d, rd_hit1_q, rd_hit1_d, evict_q, evict_d;
  logic [DW-1:0]      rd_data0_q, rd_data0_d, rd_data1_q, rd_data1_d;

  logic [NUM_RED-1:0] c_hit, r0_hit, r1_hit, w0_hit, w1_hit;
  logic [NUM_RED-1:0] alloc_sel, corr_row, touch_vec;
  logic [DW-1:0]      upd_data [NUM_RED];
  logic [RW-1:0]      old_rank;
  logic [CW-1:0]      cnt;
  logic               c_any, found;

  always_comb begin
    for (int i = 0; i < NUM_RED; i++) begin
      c_hit[i]  = bus.correct_en & valid_q[i] & (addr_q[i] == bus.correct_addr);
      r0_hit[i] = bus.rd_en      & valid_q[i] & (addr_q[i] == bus.rd_addr0);
      r1_hit[i] = bus.rd_en      & valid_q[i] & (addr_q[i] == bus.rd_addr1);
      w0_hit[i] = bus.wr_en0     & valid_q[i] & (addr_q[i] == bus.wr_addr0);
      w1_hit[i] = bus.wr_en1     & valid_q[i] & (addr_q[i] == bus.wr_addr1);
    end
    c_any = |c_hit;
  end

  // Allocation target: lowest invalid row, else the least recently used one.
  always_comb begin
    alloc_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_RED; i++) begin
      if (!valid_q[i] && !found) begin
        alloc_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
    if (!found) begin
      for (int i = 0; i < NUM_RED; i++) begin
        alloc_sel[i] = (rank_q[i] == RW'(NUM_RED - 1));
      end
    end
    corr_row = c_any ? c_hit : (bus.correct_en ? alloc_sel : '0);
    evict_d  = bus.correct_en & ~c_any & ~found & ~bus.flush;
  end

  // Same-address updates feed both the row state and the write-first read path.
  always_comb begin
    for (int i = 0; i < NUM_RED; i++) begin
      if (c_hit[i])       upd_data[i] = bus.correct_data;
      else if (w1_hit[i]) upd_data[i] = bus.wr_data1;
      else if (w0_hit[i]) upd_data[i] = bus.wr_data0;
      else                upd_data[i] = data_q[i];
    end
    valid_d = bus.flush ? '0 : (valid_q | corr_row);
    for (int i = 0; i < NUM_RED; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
      if (!bus.flush) begin
        data_d[i] = upd_data[i];
        if (corr_row[i] && !c_any) begin
          addr_d[i] = bus.correct_addr;
          data_d[i] = bus.correct_data;
        end
      end
    end
  end

  always_comb begin
    if (bus.correct_en)                 touch_vec = corr_row;
    else if (bus.rd_en && bus.touch_en) touch_vec = (|r0_hit) ? r0_hit : r1_hit;
    else                                touch_vec = '0;
    old_rank = '0;
    for (int i = 0; i < NUM_RED; i++) begin
      old_rank = old_rank | (touch_vec[i] ? rank_q[i] : '0);
    end
    for (int i = 0; i < NUM_RED; i++) begin
      rank_d[i] = rank_q[i];
      if (!bus.flush && (|touch_vec)) begin
        if (touch_vec[i])               rank_d[i] = '0;
        else if (rank_q[i] < old_rank)  rank_d[i] = rank_q[i] + RW'(1);
      end
    end
  end

  always_comb begin
    rd_hit0_d  = (|r0_hit) & ~bus.flush;
    rd_hit1_d  = (|r1_hit) & ~bus.flush;
    rd_data0_d = '0;
    rd_data1_d = '0;
    for (int i = 0; i < NUM_RED; i++) begin
      if (r0_hit[i] && rd_hit0_d) rd_data0_d = rd_data0_d | upd_data[i];
      if (r1_hit[i] && rd_hit1_d) rd_data1_d = rd_data1_d | upd_data[i];
    end
    cnt = '0;
    for (int i = 0; i < NUM_RED; i++) begin
      cnt = cnt + CW'(valid_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid_q    <= '0;
      for (int i = 0; i < NUM_RED; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        rank_q[i] <= RW'(i);
      end
      rd_hit0_q  <= 1'b0;
      rd_hit1_q  <= 1'b0;
      rd_data0_q <= '0;
      rd_data1_q <= '0;
      evict_q    <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rank_q     <= rank_d;
      rd_hit0_q  <= rd_hit0_d;
      rd_hit1_q  <= rd_hit1_d;
      rd_data0_q <= rd_data0_d;
      rd_data1_q <= rd_data1_d;
      evict_q    <= evict_d;
    end
  end

  assign bus.rd_hit0   = rd_hit0_q;
  assign bus.rd_hit1   = rd_hit1_q;
  assign bus.rd_data0  = rd_data0_q;
  assign bus.rd_data1  = rd_data1_q;
  assign bus.evict     = evict_q;
  assign bus.valid_cnt = cnt;
  assign bus.full      = (cnt == CW'(NUM_RED));
endmodule
`default_nettype wire

// File: tb/tb_el2_ifu_iccm_red_cam.sv
`default_nettype none
// ============================================================================
// tb_el2_ifu_iccm_red_cam : scoreboard bench with an LRU-list reference model
// Revision: 1.0
// ============================================================================
module tb_el2_ifu_iccm_red_cam;
  localparam int NR = 4;
  localparam int AW = 14;
  localparam int DW = 39;

  typedef struct {
    bit            h0, h1, ev, full;
    logic [DW-1:0] d0, d1;
    int            cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  // Reference state: rows plus a recency list (front = most recently used).
  bit            m_valid [NR];
  logic [AW-1:0] m_addr  [NR];
  logic [DW-1:0] m_data  [NR];
  int            lru[$];

  el2_ifu_iccm_red_cam_if #(.NUM_RED(NR), .AW(AW), .DW(DW)) bus ();
  el2_ifu_iccm_red_cam #(.NUM_RED(NR), .AW(AW), .DW(DW)) u_dut (
    .clk(clk), .rst_l(rst_l), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int find(input logic [AW-1:0] a);
    for (int i = 0; i < NR; i++) if (m_valid[i] && m_addr[i] == a) return i;
    return -1;
  endfunction

  function automatic void touch(input int r);
    for (int k = 0; k < lru.size(); k++) if (lru[k] == r) begin lru.delete(k); break; end
    lru.push_front(r);
  endfunction

  function automatic void model_reset();
    lru = {};
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 0; m_addr[i] = '0; m_data[i] = '0; lru.push_back(i);
    end
  endfunction

  function automatic logic [DW-1:0] newest(input logic [AW-1:0] a, input logic [DW-1:0] old);
    logic [DW-1:0] v = old;
    if (bus.wr_en0 && bus.wr_addr0 == a) v = bus.wr_data0;
    if (bus.wr_en1 && bus.wr_addr1 == a) v = bus.wr_data1;
    if (bus.correct_en && bus.correct_addr == a) v = bus.correct_data;
    return v;
  endfunction

  task automatic clr();
    bus.rd_en = 0; bus.rd_addr0 = '0; bus.rd_addr1 = '0;
    bus.wr_en0 = 0; bus.wr_en1 = 0; bus.wr_addr0 = '0; bus.wr_addr1 = '0;
    bus.wr_data0 = '0; bus.wr_data1 = '0;
    bus.correct_en = 0; bus.correct_addr = '0; bus.correct_data = '0;
    bus.touch_en = 0; bus.flush = 0;
  endtask

  task automatic start();
    @(negedge clk);
    clr();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Applies the current inputs to the model and queues the expected outputs.
  task automatic step();
    exp_t e;
    int r0, r1, m;
    r0 = bus.rd_en ? find(bus.rd_addr0) : -1;
    r1 = bus.rd_en ? find(bus.rd_addr1) : -1;
    e.h0 = !bus.flush && r0 >= 0;
    e.h1 = !bus.flush && r1 >= 0;
    e.d0 = e.h0 ? newest(bus.rd_addr0, m_data[r0]) : '0;
    e.d1 = e.h1 ? newest(bus.rd_addr1, m_data[r1]) : '0;
    e.ev = 0;
    if (bus.flush) begin
      for (int i = 0; i < NR; i++) m_valid[i] = 0;
    end else begin
      if (bus.wr_en0) begin m = find(bus.wr_addr0); if (m >= 0) m_data[m] = bus.wr_data0; end
      if (bus.wr_en1) begin m = find(bus.wr_addr1); if (m >= 0) m_data[m] = bus.wr_data1; end
      if (bus.correct_en) begin
        m = find(bus.correct_addr);
        if (m < 0) begin
          for (int i = NR - 1; i >= 0; i--) if (!m_valid[i]) m = i;
          if (m < 0) begin m = lru[$]; e.ev = 1; end
          m_valid[m] = 1;
          m_addr[m]  = bus.correct_addr;
        end
        m_data[m] = bus.correct_data;
        touch(m);
      end else if (bus.rd_en && bus.touch_en) begin
        if (r0 >= 0) touch(r0);
        else if (r1 >= 0) touch(r1);
      end
    end
    e.cnt = 0;
    for (int i = 0; i < NR; i++) e.cnt += int'(m_valid[i]);
    e.full = (e.cnt == NR);
    sb.push_back(e);
  endtask

  task automatic corr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    start();
    bus.correct_en = 1; bus.correct_addr = a; bus.correct_data = d;
    step();
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] v = AW'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) v = v | AW'(14'h2000);
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  // Monitor: every registered output cycle is compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_l && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_hit0", 64'(bus.rd_hit0), 64'(e.h0));
        chk("sb_hit1", 64'(bus.rd_hit1), 64'(e.h1));
        chk("sb_data0", 64'(bus.rd_data0), 64'(e.d0));
        chk("sb_data1", 64'(bus.rd_data1), 64'(e.d1));
        chk("sb_evict", 64'(bus.evict), 64'(e.ev));
        chk("sb_cnt", 64'(bus.valid_cnt), 64'(e.cnt));
        chk("sb_full", 64'(bus.full), 64'(e.full));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 64'(bus.valid_cnt), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_hit0", 64'(bus.rd_hit0), 64'd0);
    chk("rst_evict", 64'(bus.evict), 64'd0);
    @(negedge clk);
    rst_l = 1'b1;

    // Allocate then read back.
    corr(14'h010, 39'h0AA);
    start(); bus.rd_en = 1; bus.rd_addr0 = 14'h010; step();
    settle();
    chk("alloc_hit0", 64'(bus.rd_hit0), 64'd1);
    chk("alloc_data0", 64'(bus.rd_data0), 64'h0AA);
    chk("alloc_cnt", 64'(bus.valid_cnt), 64'd1);

    // Fill, then evict the least recently used row.
    start(); bus.flush = 1; step();
    for (int k = 1; k <= 4; k++) corr(AW'(k), DW'(k * 16));
    settle();
    chk("fill_full", 64'(bus.full), 64'd1);
    corr(14'h005, 39'h50);
    settle();
    chk("lru_evict", 64'(bus.evict), 64'd1);
    start(); bus.rd_en = 1; bus.rd_addr0 = 14'h001; bus.rd_addr1 = 14'h005; step();
    settle();
    chk("lru_old_gone", 64'(bus.rd_hit0), 64'd0);
    chk("lru_new_hit", 64'(bus.rd_hit1), 64'd1);
    chk("lru_evict_pulse", 64'(bus.evict), 64'd0);

    // A touching read protects 0x1; 0x2 becomes the victim.
    start(); bus.flush = 1; step();
    for (int k = 1; k <= 4; k++) corr(AW'(k), DW'(k * 16));
    start(); bus.rd_en = 1; bus.touch_en = 1; bus.rd_addr0 = 14'h001; step();
    corr(14'h005, 39'h50);
    start(); bus.rd_en = 1; bus.rd_addr0 = 14'h002; bus.rd_addr1 = 14'h001; step();
    settle();
    chk("touch_victim", 64'(bus.rd_hit0), 64'd0);
    chk("touch_kept", 64'(bus.rd_hit1), 64'd1);

    // Correction beats both write ports; the same-cycle read sees the new data.
    start(); bus.flush = 1; step();
    corr(14'h010, 39'h999);
    start();
    bus.wr_en0 = 1; bus.wr_addr0 = 14'h010; bus.wr_data0 = 39'h111;
    bus.wr_en1 = 1; bus.wr_addr1 = 14'h010; bus.wr_data1 = 39'h222;
    bus.correct_en = 1; bus.correct_addr = 14'h010; bus.correct_data = 39'h333;
    bus.rd_en = 1; bus.rd_addr0 = 14'h010;
    step();
    settle();
    chk("prio_data", 64'(bus.rd_data0), 64'h333);
    chk("prio_nodup", 64'(bus.valid_cnt), 64'd1);

    // Flush wins over a same-cycle correction.
    start(); bus.flush = 1; bus.correct_en = 1; bus.correct_addr = 14'h010; bus.correct_data = 39'h7; step();
    start(); bus.rd_en = 1; bus.rd_addr0 = 14'h010; step();
    settle();
    chk("flush_cnt", 64'(bus.valid_cnt), 64'd0);
    chk("flush_miss", 64'(bus.rd_hit0), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      start();
      bus.rd_en    = ($urandom_range(0, 9) < 7);
      bus.rd_addr0 = rnd_addr();
      bus.rd_addr1 = rnd_addr();
      bus.touch_en = $urandom_range(0, 1) == 1;
      bus.wr_en0   = ($urandom_range(0, 9) < 3);
      bus.wr_addr0 = rnd_addr();
      bus.wr_data0 = rnd_data();
      bus.wr_en1   = ($urandom_range(0, 9) < 3);
      bus.wr_addr1 = ($urandom_range(0, 2) == 0) ? bus.wr_addr0 : rnd_addr();
      bus.wr_data1 = rnd_data();
      bus.correct_en   = ($urandom_range(0, 3) == 0);
      bus.correct_addr = rnd_addr();
      bus.correct_data = rnd_data();
      bus.flush    = ($urandom_range(0, 39) == 0);
      step();
    end

    // Asynchronous reset while a hitting read is registered.
    corr(14'h010, 39'h0AA);
    start(); bus.rd_en = 1; bus.rd_addr0 = 14'h010; step();
    @(posedge clk);
    #3;
    rst_l = 1'b0;
    #1;
    chk("areset_hit0", 64'(bus.rd_hit0), 64'd0);
    chk("areset_cnt", 64'(bus.valid_cnt), 64'd0);
    sb = {};
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    start(); bus.rd_en = 1; bus.rd_addr0 = 14'h010; step();
    start(); step();
    settle();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/el2_ifu_iccm_red_cam.md
EL2_IFU_ICCM_RED_CAM -- requirements
Module: el2_ifu_iccm_red_cam

Interface
REQ-001 SHALL have parameter NUM_RED, default 4: number of redundant rows, legal 2..16.
REQ-002 SHALL have parameter AW, default 14: word-address width (ICCM address bits hi:2).
REQ-003 SHALL have parameter DW, default 39: row width (32 data + 7 ECC).
REQ-004 SHALL have one clock; reset is asynchronous and active-low: clk in 1, rst_l in 1.
REQ-005 SHALL have ports (name, direction, width, meaning):
- rd_en  in 1  ICCM read this cycle.
- rd_addr0, rd_addr1  in AW each  lower and upper word addresses of the read.
- wr_en0, wr_en1  in 1 each  word write enables.
- wr_addr0, wr_addr1  in AW each  word write addresses.
- wr_data0, wr_data1  in DW each  word write data.
- correct_en  in 1  single-bit-error correction write.
- correct_addr  in AW  address of the corrected word.
- correct_data  in DW  corrected row.
- touch_en  in 1  read hits update LRU; tied to correction state.
- flush  in 1  invalidate all rows.
- rd_hit0, rd_hit1  out 1 each  registered redundant hit per read word.
- rd_data0, rd_data1  out DW each  registered redundant row data.
- full  out 1  all rows valid.
- evict  out 1  one-cycle pulse: valid row replaced.
- valid_cnt  out $clog2(NUM_RED+1)  number of valid rows.

Function
REQ-006 SHALL hold NUM_RED rows, each with valid, addr[AW], data[DW] and rank[$clog2(NUM_RED)]; ranks always form a permutation of 0..NUM_RED-1.
REQ-007 SHALL match a lookup address against valid rows only; at most one row per address at any time.
REQ-008 SHALL, on rd_en, register rd_hitN and rd_dataN at the next edge; latency one cycle; rd_dataN = 0 when rd_hitN = 0.
REQ-009 SHALL drive rd_hitN = 0 in every cycle following a cycle with rd_en = 0.
REQ-010 SHALL give rd_addr0 and rd_addr1 independent lookups; both may hit the same row.
REQ-011 SHALL make reads write-first: a same-cycle write or correction to a hit address returns the new data.
REQ-012 SHALL update row data on wr_enN when wr_addrN matches a valid row; no allocation on writes.
REQ-013 SHALL give wr port 1 priority over port 0 when both write the same row.
REQ-014 SHALL, on correct_en with correct_addr matching a valid row, overwrite that row's data and touch it.
REQ-015 SHALL, on correct_en with no match, allocate the lowest-index invalid row; if none is invalid, replace the row with rank NUM_RED-1 and pulse evict.
REQ-016 SHALL give correction data priority over both write ports on the same row in the same cycle.
REQ-017 SHALL implement touch as: touched row rank := 0; every row with a rank below the old rank increments by 1; all other ranks unchanged.
REQ-018 SHALL touch on allocation and on correction hit, and also on read hit when rd_en & touch_en; correction touch wins and read touches are dropped in that cycle; if both read ports hit different rows, port 0's row is touched.
REQ-019 SHALL make flush clear all valid bits at the next edge, with priority over correction, write and touch in the same cycle; ranks are untouched; rd_hit is registered as 0.
REQ-020 SHALL derive full = (valid_cnt == NUM_RED), registered with the row state; evict is registered, high exactly one cycle.
REQ-021 SHALL compute all address compares at full AW width without wrap; rank arithmetic never exceeds NUM_RED-1.

Reset
REQ-022 SHALL, on rst_l low, asynchronously clear all valid bits, row addr and data to 0, rank of row i to i, and all outputs to 0.
REQ-023 SHALL discard any correction or read in flight when reset asserts mid-operation; no allocation or hit survives reset.

Verification (NUM_RED=4, AW=14, DW=39)
REQ-024 SHALL cover: reset, then correct 0x010 / 0x0AA -> row0 allocated; next cycle rd_addr0=0x010 -> rd_hit0=1, rd_data0=0x0AA, valid_cnt=1.
REQ-025 SHALL cover: corrections to 0x1,0x2,0x3,0x4, then 0x5 -> full=1 before 0x5; 0x5 replaces row holding 0x1; evict pulses 1 cycle.
REQ-026 SHALL cover: same as REQ-025 but read 0x1 with touch_en=1 before 0x5 -> row holding 0x2 is replaced instead.
REQ-027 SHALL cover: same cycle wr_en0 0x010/0x111, wr_en1 0x010/0x222, correct 0x010/0x333 -> row data 0x333; no duplicate row.
REQ-028 SHALL cover: flush and correct_en same cycle -> valid_cnt=0, no allocation; rd_en 0x010 next cycle -> rd_hit0=0.
REQ-029 SHALL cover: rst_l low during an rd_en cycle that hits -> rd_hit0=0 and valid_cnt=0 immediately.
